ksa_swap_fsm: RTL

Key-scheduling stage of the RC4 datapath. It runs immediately after the S-array initialiser: once S[i] = i for i = 0..255, it walks i = 0..255, computes j = j + S[i] + key[i mod KEY_BYTES] (mod 256), and swaps S[i] and S[j] in the shared 256x8 working RAM. Its `start` is driven by the initialiser's `finish`. RAM port muxing between stages is done outside this block.

---
 rtl/ksa_swap_fsm.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ksa_swap_fsm.sv
// RC4 key-scheduling stage: walks i = 0..255, accumulates j = j + S[i] + key[k] and
// swaps S[i]/S[j] in the shared working RAM (synchronous read, registered address).
module ksa_swap_fsm #(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [7:0]             mem_q,
    output logic [7:0]             mem_addr,
    output logic [7:0]             wr_data,
    output logic                   wr_en,
    output logic                   busy,
    output logic                   finish
);

    localparam int              KW     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KW-1:0]   K_LAST = KW'(KEY_BYTES - 1);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_RD_I   = 4'd1,
        ST_WAIT_I = 4'd2,
        ST_CAP_I  = 4'd3,
        ST_RD_J   = 4'd4,
        ST_WAIT_J = 4'd5,
        ST_CAP_J  = 4'd6,
        ST_WR_I   = 4'd7,
        ST_WR_J   = 4'd8,
        ST_NEXT   = 4'd9,
        ST_DONE   = 4'd10
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [7:0]      i_r, i_nxt_s;
    logic [7:0]      j_r, j_nxt_s;
    logic [KW-1:0]   k_r, k_nxt_s;
    logic [7:0]      si_r, si_nxt_s;
    logic [7:0]      sj_r, sj_nxt_s;
    logic [7:0]      key_byte_s;
    logic [7:0]      mem_addr_s;
    logic [7:0]      wr_data_s;
    logic            wr_en_s;
    logic            busy_s;
    logic            finish_s;

    // Byte 0 of the key sits in the most significant position.
    function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES-1:0] key,
                                            input logic [KW-1:0]          idx);
        logic [7:0] b;
        b = 8'd0;
        for (int n = 0; n < KEY_BYTES; n++) begin
            b = (idx == KW'(n)) ? key[8*(KEY_BYTES-1-n) +: 8] : b;
        end
        return b;
    endfunction

    assign key_byte_s = key_byte(secret_key, k_r);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            i_r     <= 8'd0;
            j_r     <= 8'd0;
            k_r     <= '0;
            si_r    <= 8'd0;
            sj_r    <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            i_r     <= i_nxt_s;
            j_r     <= j_nxt_s;
            k_r     <= k_nxt_s;
            si_r    <= si_nxt_s;
            sj_r    <= sj_nxt_s;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt_s = state_r;
        i_nxt_s     = i_r;
        j_nxt_s     = j_r;
        k_nxt_s     = k_r;
        si_nxt_s    = si_r;
        sj_nxt_s    = sj_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RD_I;
                    i_nxt_s     = 8'd0;
                    j_nxt_s     = 8'd0;
                    k_nxt_s     = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_I:   state_nxt_s = ST_WAIT_I;
            ST_WAIT_I: state_nxt_s = ST_CAP_I;
            ST_CAP_I: begin
                si_nxt_s    = mem_q;
                j_nxt_s     = j_r + mem_q + key_byte_s;
                state_nxt_s = ST_RD_J;
            end
            ST_RD_J:   state_nxt_s = ST_WAIT_J;
            ST_WAIT_J: state_nxt_s = ST_CAP_J;
            ST_CAP_J: begin
                sj_nxt_s    = mem_q;
                state_nxt_s = ST_WR_I;
            end
            ST_WR_I:   state_nxt_s = ST_WR_J;
            ST_WR_J:   state_nxt_s = ST_NEXT;
            ST_NEXT: begin
                if (i_r == 8'd255) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    i_nxt_s     = i_r + 8'd1;
                    k_nxt_s     = (k_r == K_LAST) ? '0 : k_r + KW'(1);
                    state_nxt_s = ST_RD_I;
                end
            end
            ST_DONE:   state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Outputs decoded from the upcoming state so they can be registered without added latency.
    always_comb begin
        mem_addr_s = 8'd0;
        wr_data_s  = 8'd0;
        wr_en_s    = 1'b0;
        busy_s     = 1'b0;
        finish_s   = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_RD_I, ST_WAIT_I, ST_CAP_I, ST_NEXT: begin
                mem_addr_s = i_nxt_s;
                busy_s     = 1'b1;
            end
            ST_RD_J, ST_WAIT_J, ST_CAP_J: begin
                mem_addr_s = j_nxt_s;
                busy_s     = 1'b1;
            end
            ST_WR_I: begin
                mem_addr_s = i_nxt_s;
                wr_data_s  = sj_nxt_s;
                wr_en_s    = 1'b1;
                busy_s     = 1'b1;
            end
            ST_WR_J: begin
                mem_addr_s = j_nxt_s;
                wr_data_s  = si_nxt_s;
                wr_en_s    = 1'b1;
                busy_s     = 1'b1;
            end
            ST_DONE: begin
                finish_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Output registers; reset clears them at once so a write in flight is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr <= 8'd0;
            wr_data  <= 8'd0;
            wr_en    <= 1'b0;
            busy     <= 1'b0;
            finish   <= 1'b0;
        end else begin
            mem_addr <= mem_addr_s;
            wr_data  <= wr_data_s;
            wr_en    <= wr_en_s;
            busy     <= busy_s;
            finish   <= finish_s;
        end
    end

endmodule
